sd_adc_decimator: RTL and testbench
===================================

Name: sd_adc_decimator

Overview:
- 1-bit sigma-delta audio ADC front end. It is the capture-direction counterpart of the sigma-delta DAC output path.
- An external comparator and RC integrator sit on the EAR/line input. This block drives the comparator feedback pin and decimates the resulting bitstream into unsigned 8-bit samples (excess-128).
- It also derives a hysteresis-cleaned digital EAR level for the ULA/port logic.

Parameters:
- OSR_LOG2, 8: log2 of decimation window length in ce-qualified cycles; must be >= OUT_W.
- OUT_W, 8: sample width.
- HYST, 16: EAR hysteresis half-width around midscale (128).
- SETTLE_WIN, 2: windows discarded after reset; range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low. Synchronous to clk (sampled on posedge clk only).
- ce  in  1  sample-rate clock enable. Integration and window advance only when high.
- cmp_in  in  1  asynchronous comparator output (1 = input above integrator).
- fb_out  out  1  registered feedback to RC integrator. Place in IOB.
- sample  out  OUT_W  last decimated sample, unsigned, midscale 128.
- sample_valid  out  1  one-clk pulse when sample updates.
- ear_bit  out  1  hysteresis-filtered digital level.
- overload  out  1  last window was all-0 or all-1 (clipped).

Behaviour:
- Reset (rst_n low at posedge clk): all outputs are forced as listed below. Reset overrides everything, including mid-window.
  - sync regs = 0; fb_out = 0; phase = 0; acc = 0
  - sample = 128; sample_valid = 0; ear_bit = 0; overload = 0
  - state = SETTLE; settle_cnt = 0
- Sync: cmp_in passes through a 2-FF synchroniser (s1, s2) every clk, regardless of ce.
- fb_out <= s2 every clk. Latency from cmp_in to fb_out is 3 clks.
- Window:
  - phase is an OSR_LOG2-bit counter; acc is OSR_LOG2+1 bits.
  - On each clk with ce=1: acc += fb_out; phase += 1 (wraps).
  - ce=0 holds phase and acc.
- Window end is a ce=1 clk with phase == 2^OSR_LOG2-1. On that clk:
  - total = acc + fb_out, range 0..2^OSR_LOG2.
  - acc <= 0 (the final bit is included in total, not carried over).
  - scaled = total >> (OSR_LOG2-OUT_W). If scaled == 2^OUT_W, saturate to 2^OUT_W-1.
  - overload_next = (total == 0) || (total == 2^OSR_LOG2).
- FSM:
  - SETTLE: on each window end, settle_cnt += 1. When settle_cnt == SETTLE_WIN-1 at a window end, go to RUN. No update to sample, overload or ear_bit, and no sample_valid, while in SETTLE (including the transition window).
  - RUN: on each window end:
    - sample <= scaled; overload <= overload_next; sample_valid <= 1 (high on the following clk, for exactly 1 clk).
    - ear_bit <= 1 if scaled >= 128+HYST.
    - ear_bit <= 0 if scaled < 128-HYST.
    - Otherwise ear_bit holds.
  - RUN stays in RUN until reset.
- sample_valid is 0 on every other clk. Spacing between valid pulses is 2^OSR_LOG2 ce-cycles.
- ce and window end: ce deasserted on what would be the window-end clk delays the window end to the next ce=1 clk.
- Reset mid-window: the partial acc is discarded and SETTLE restarts from 0. No valid pulse is emitted for the partial window.
- Arithmetic is unsigned throughout. The acc width must hold 2^OSR_LOG2 without wrap.

Test Plan:
- Reset release with cmp_in=0:
  - Outputs hold reset values.
  - No sample_valid for the first SETTLE_WIN*256 ce-cycles.
  - First valid appears 1 clk after the 768th ce-cycle window end, with sample=0 and overload=1.
- cmp_in held 1, ce=1 constant, defaults:
  - After settle: sample=255 (saturated from 256), overload=1, ear_bit=1.
  - Valid pulses every 256 clks.
- cmp_in toggling each clk (fb 50% duty): sample=128, overload=0, ear_bit unchanged from its prior value.
- Hysteresis: force densities giving scaled = 150, 130, 120, 111, 112.
  - Required ear_bit: 1, 1, 1, 0, 0.
  - Starting from 0, scaled = 143 then 144 gives 0 then 1.
- ce asserted every other clk with cmp_in=1: valid spacing is 512 clks; sample stays 255.
- rst_n pulsed low for 1 clk at phase 100 of a RUN window:
  - The next clk shows reset values; fb_out=0.
  - No valid occurs until SETTLE_WIN full windows after release.
  - The first post-reset sample reflects only post-reset bits.

Source files
------------

// File: rtl/sd_adc_decimator.sv
// sd_adc_decimator: 1-bit sigma-delta capture loop, window decimator and hysteresis EAR slicer
module sd_adc_decimator #(
    parameter int OSR_LOG2   = 8,
    parameter int OUT_W      = 8,
    parameter int HYST       = 16,
    parameter int SETTLE_WIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             cmp_in,
    output logic             fb_out,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             ear_bit,
    output logic             overload
);
    localparam logic [0:0]          SETTLE  = 1'b0;
    localparam logic [0:0]          RUN     = 1'b1;
    localparam int                  MID     = 1 << (OUT_W - 1);
    localparam logic [OUT_W-1:0]    MID_V   = OUT_W'(MID);
    localparam logic [OUT_W-1:0]    HI      = OUT_W'(MID + HYST);
    localparam logic [OUT_W-1:0]    LO      = OUT_W'(MID - HYST);
    localparam logic [OSR_LOG2:0]   FULL    = {1'b1, {OSR_LOG2{1'b0}}};
    localparam logic [3:0]          SW_LAST = 4'(SETTLE_WIN - 1);

    logic                s1, s2;
    logic [OSR_LOG2-1:0] phase;
    logic [OSR_LOG2:0]   acc, total, shifted;
    logic [OUT_W-1:0]    scaled;
    logic                win_end, ovl_next;
    logic [0:0]          state;
    logic [3:0]          settle_cnt;

    // the window-end bit is folded into total so acc can restart cleanly at 0
    always_comb begin
        win_end  = ce && (phase == '1);
        total    = acc + {{OSR_LOG2{1'b0}}, fb_out};
        shifted  = total >> (OSR_LOG2 - OUT_W);
        scaled   = shifted[OUT_W] ? '1 : shifted[OUT_W-1:0];
        ovl_next = (total == '0) || (total == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            fb_out       <= 1'b0;
            phase        <= '0;
            acc          <= '0;
            sample       <= MID_V;
            sample_valid <= 1'b0;
            ear_bit      <= 1'b0;
            overload     <= 1'b0;
            state        <= SETTLE;
            settle_cnt   <= '0;
        end else begin
            s1           <= cmp_in;
            s2           <= s1;
            fb_out       <= s2;
            sample_valid <= 1'b0;
            if (ce) begin
                phase <= phase + 1'b1;
                acc   <= win_end ? '0 : total;
            end
            if (win_end) begin
                if (state == SETTLE) begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SW_LAST) state <= RUN;
                end else begin
                    sample       <= scaled;
                    overload     <= ovl_next;
                    sample_valid <= 1'b1;
                    ear_bit      <= (scaled >= HI) ? 1'b1 : (scaled < LO) ? 1'b0 : ear_bit;
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_adc_decimator.sv
// tb_sd_adc_decimator: window-level reference model plus directed table and corner sequences
module tb_sd_adc_decimator;
    localparam int OSR = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, ce = 1'b0, cmp_in = 1'b0;
    logic       fb_out, sample_valid, ear_bit, overload;
    logic [7:0] sample;

    sd_adc_decimator dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cmp_in(cmp_in),
        .fb_out(fb_out), .sample(sample), .sample_valid(sample_valid),
        .ear_bit(ear_bit), .overload(overload)
    );

    always #5 clk = ~clk;

    typedef struct { int k; logic [7:0] s; logic e; } vec_t;
    vec_t tbl[7];

    int checks = 0, failures = 0, stepno = 0;
    logic pq[$];
    int m_n, m_ones, m_wins;
    logic [7:0] m_sample;
    logic m_valid, m_ear, m_ovl, m_fb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    // bits reach the counter three clocks after the comparator; windows are 256 enabled clocks
    task automatic model(input logic r, input logic c, input logic m);
        logic b;
        int sc;
        if (!r) begin
            pq = '{1'b0, 1'b0, 1'b0};
            m_n = 0; m_ones = 0; m_wins = 0;
            m_sample = 8'd128; m_valid = 0; m_ear = 0; m_ovl = 0; m_fb = 0;
        end else begin
            b = pq.pop_front();
            pq.push_back(m);
            m_fb = pq[0];
            m_valid = 0;
            if (c) begin
                m_ones += int'(b);
                m_n++;
                if (m_n == OSR) begin
                    m_wins++;
                    if (m_wins > 2) begin
                        sc = (m_ones > 255) ? 255 : m_ones;
                        m_sample = 8'(sc);
                        m_ovl = (m_ones == 0) || (m_ones == OSR);
                        m_valid = 1;
                        if (sc >= 144) m_ear = 1;
                        else if (sc < 112) m_ear = 0;
                    end
                    m_n = 0;
                    m_ones = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic m);
        @(negedge clk);
        rst_n = r; ce = c; cmp_in = m;
        @(posedge clk);
        stepno++;
        model(r, c, m);
        #1;
        chk("valid", sample_valid, m_valid);
        chk("sample", sample, m_sample);
        chk("overload", overload, m_ovl);
        chk("ear", ear_bit, m_ear);
        chk("fb", fb_out, m_fb);
    endtask

    initial begin
        int cnt, last, d;
        logic got;
        tbl[0] = '{150, 8'd150, 1'b1};
        tbl[1] = '{130, 8'd130, 1'b1};
        tbl[2] = '{120, 8'd120, 1'b1};
        tbl[3] = '{111, 8'd111, 1'b0};
        tbl[4] = '{112, 8'd112, 1'b0};
        tbl[5] = '{143, 8'd143, 1'b0};
        tbl[6] = '{144, 8'd144, 1'b1};

        // reset and first valid after settling, cmp_in low
        repeat (3) step(0, 1, 0);
        chk("rst_sample", sample, 128);
        chk("rst_valid", sample_valid, 0);
        chk("rst_ear", ear_bit, 0);
        chk("rst_ovl", overload, 0);
        chk("rst_fb", fb_out, 0);
        cnt = 0; got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            step(1, 1, 0);
            cnt++;
            got = sample_valid;
        end
        chk("first_valid_at", cnt, 768);
        chk("first_sample", sample, 0);
        chk("first_ovl", overload, 1);

        // cmp_in held high: saturation and 256-clk spacing
        last = stepno;
        for (int i = 0; i < 800; i++) begin
            step(1, 1, 1);
            if (sample_valid) begin
                chk("spacing_256", stepno - last, 256);
                last = stepno;
            end
        end
        chk("sat_sample", sample, 255);
        chk("sat_ovl", overload, 1);
        chk("sat_ear", ear_bit, 1);

        // 50% density
        for (int i = 0; i < 512; i++) step(1, 1, logic'(stepno % 2));
        chk("half_sample", sample, 128);
        chk("half_ovl", overload, 0);
        chk("half_ear", ear_bit, 1);

        // hysteresis table, each entry one aligned window
        repeat (4) step(1, 1, 0);
        for (int i = 0; i < 300 && m_n != 0; i++) step(1, 1, 0);
        chk("align0", m_n, 0);
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < OSR; i++) step(1, 1, (m_n >= 10) && (m_n < 10 + tbl[t].k));
            chk("tbl_valid", sample_valid, 1);
            chk("tbl_sample", sample, tbl[t].s);
            chk("tbl_ear", ear_bit, tbl[t].e);
            chk("tbl_ovl", overload, 0);
        end

        // ce every other clock
        last = -1;
        for (int i = 0; i < 1600; i++) begin
            step(1, logic'(i % 2), 1);
            if (sample_valid) begin
                if (last >= 0) chk("spacing_512", stepno - last, 512);
                last = stepno;
            end
        end
        chk("ce_half_sample", sample, 255);

        // one-clock reset at phase 100 of a RUN window
        for (int i = 0; i < 300 && m_n != 100; i++) step(1, 1, 1);
        chk("align100", m_n, 100);
        step(0, 1, 1);
        chk("mid_rst_fb", fb_out, 0);
        chk("mid_rst_sample", sample, 128);
        chk("mid_rst_valid", sample_valid, 0);
        chk("mid_rst_ear", ear_bit, 0);
        chk("mid_rst_ovl", overload, 0);
        cnt = 0; got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            step(1, 1, 0);
            cnt++;
            got = sample_valid;
        end
        chk("post_rst_valid_at", cnt, 768);
        chk("post_rst_sample", sample, 0);

        // randomized traffic against the model
        d = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) d = $urandom_range(0, 100);
            step(logic'($urandom_range(0, 1999) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 99) < d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
